// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand channel (valid/ready) and result channel (valid/ready).
// The master side produces operands and consumes results; the slave side is the adder.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit, DIGIT bits per clock, LSB digit first, valid/ready on both sides.
// Optional macro SERIAL_ADDER_SAT_EN: saturate the sum to the signed limit when ovf is set.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: need 1 <= DIGIT <= WIDTH and WIDTH a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;
  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_digit_sum;
  logic [WIDTH-1:0] w_sum_shift;
  logic [WIDTH-1:0] w_sum_final;
  logic             w_ovf;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_next = ADD;
      end
      ADD: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_last   = (r_cnt == CW'(NDIG - 1));

  // One digit of ripple addition; the carry stays in r_c between clocks.
  assign w_digit_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
  assign w_sum_shift = (r_sum >> DIGIT) | (WIDTH'(w_digit_sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign w_ovf       = (r_a_msb == r_b_msb) & (w_sum_shift[WIDTH-1] != r_a_msb);

`ifdef SERIAL_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);
  logic [WIDTH-1:0] w_sat;
  assign w_sat       = r_a_msb ? MSB_ONLY : ~MSB_ONLY;
  assign w_sum_final = w_ovf ? w_sat : w_sum_shift;
`else
  assign w_sum_final = w_sum_shift;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_c     <= bus.sub | bus.cin;
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
            r_cnt   <= '0;
          end
        end
        ADD: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_c   <= w_digit_sum[DIGIT];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_sum_final;
            r_cout <= w_digit_sum[DIGIT];
            r_ovf  <= w_ovf;
          end else begin
            r_sum  <= w_sum_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vectors on 8x1 and 8x4 builds, then
// random back-to-back traffic on a 16x4 build against a plain arithmetic model.
module tb_serial_adder;
`ifdef SERIAL_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8))  if_8x1 ();
  serial_adder_if #(.WIDTH(8))  if_8x4 ();
  serial_adder_if #(.WIDTH(16)) if_16x4 ();

  serial_adder #(.WIDTH(8),  .DIGIT(1)) u_8x1  (.clk(clk), .rst_n(rst_n), .bus(if_8x1));
  serial_adder #(.WIDTH(8),  .DIGIT(4)) u_8x4  (.clk(clk), .rst_n(rst_n), .bus(if_8x4));
  serial_adder #(.WIDTH(16), .DIGIT(4)) u_16x4 (.clk(clk), .rst_n(rst_n), .bus(if_16x4));

  int          sel = 0;
  logic        tb_in_valid = 1'b0;
  logic        tb_out_ready = 1'b1;
  logic [15:0] tb_a = '0;
  logic [15:0] tb_b = '0;
  logic        tb_cin = 1'b0;
  logic        tb_sub = 1'b0;

  assign if_8x1.in_valid  = tb_in_valid && (sel == 0);
  assign if_8x1.a         = tb_a[7:0];
  assign if_8x1.b         = tb_b[7:0];
  assign if_8x1.cin       = tb_cin;
  assign if_8x1.sub       = tb_sub;
  assign if_8x1.out_ready = tb_out_ready;
  assign if_8x4.in_valid  = tb_in_valid && (sel == 1);
  assign if_8x4.a         = tb_a[7:0];
  assign if_8x4.b         = tb_b[7:0];
  assign if_8x4.cin       = tb_cin;
  assign if_8x4.sub       = tb_sub;
  assign if_8x4.out_ready = tb_out_ready;
  assign if_16x4.in_valid  = tb_in_valid && (sel == 2);
  assign if_16x4.a         = tb_a;
  assign if_16x4.b         = tb_b;
  assign if_16x4.cin       = tb_cin;
  assign if_16x4.sub       = tb_sub;
  assign if_16x4.out_ready = tb_out_ready;

  logic        o_in_ready, o_out_valid, o_cout, o_ovf, o_busy;
  logic [15:0] o_sum;
  always_comb begin
    o_in_ready  = if_8x1.in_ready;
    o_out_valid = if_8x1.out_valid;
    o_sum       = {8'h00, if_8x1.sum};
    o_cout      = if_8x1.cout;
    o_ovf       = if_8x1.ovf;
    o_busy      = if_8x1.busy;
    if (sel == 1) begin
      o_in_ready  = if_8x4.in_ready;
      o_out_valid = if_8x4.out_valid;
      o_sum       = {8'h00, if_8x4.sum};
      o_cout      = if_8x4.cout;
      o_ovf       = if_8x4.ovf;
      o_busy      = if_8x4.busy;
    end else if (sel == 2) begin
      o_in_ready  = if_16x4.in_ready;
      o_out_valid = if_16x4.out_valid;
      o_sum       = if_16x4.sum;
      o_cout      = if_16x4.cout;
      o_ovf       = if_16x4.ovf;
      o_busy      = if_16x4.busy;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;

  always @(posedge clk)
    if (rst_n && if_16x4.out_valid && if_16x4.out_ready) n_xfer <= n_xfer + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with out_ready held high; checks latency and results.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input logic [15:0] e_sum,
                       input logic e_cout, input logic e_ovf, input int e_lat);
    int lat;
    tb_a = a; tb_b = b; tb_cin = cin; tb_sub = sub;
    tb_in_valid  = 1'b1;
    tb_out_ready = 1'b1;
    check({tag, "_in_ready_idle"}, 32'(o_in_ready), 32'd1);
    tick();
    tb_in_valid = 1'b0;
    tb_a = ~a; tb_b = ~b; tb_cin = ~cin; tb_sub = ~sub;
    check({tag, "_busy"}, 32'(o_busy), 32'd1);
    lat = 0;
    while (!o_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check({tag, "_sum"}, 32'(o_sum), 32'(e_sum));
    check({tag, "_cout"}, 32'(o_cout), 32'(e_cout));
    check({tag, "_ovf"}, 32'(o_ovf), 32'(e_ovf));
    check({tag, "_in_ready_done"}, 32'(o_in_ready), 32'd0);
    tick();
    check({tag, "_out_valid_after"}, 32'(o_out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] ra, rb, e_sum;
    logic        rc, rs, e_ovf;
    logic [16:0] full;
    int          guard;

    sel = 0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(o_in_ready), 32'd1);
    check("rst_out_valid", 32'(o_out_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_sum", 32'(o_sum), 32'd0);
    check("rst_cout", 32'(o_cout), 32'd0);
    check("rst_ovf", 32'(o_ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    // WIDTH=8, DIGIT=1
    do_op("add_35_4a", 16'h35, 16'h4A, 1'b0, 1'b0, 16'h7F, 1'b0, 1'b0, 8);
    do_op("add_ff_01_c1", 16'hFF, 16'h01, 1'b1, 1'b0, 16'h01, 1'b1, 1'b0, 8);
    do_op("add_7f_01", 16'h7F, 16'h01, 1'b0, 1'b0, SAT ? 16'h7F : 16'h80, 1'b0, 1'b1, 8);
    do_op("add_ff_01_wrap", 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 8);

    // Backpressure: result held, new operands ignored, single transfer
    tb_a = 16'h10; tb_b = 16'h20; tb_cin = 1'b0; tb_sub = 1'b0;
    tb_out_ready = 1'b0;
    tb_in_valid  = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    guard = 0;
    while (!o_out_valid && guard < 40) begin
      tick();
      guard++;
    end
    check("bp_latency", 32'(guard), 32'd8);
    tb_in_valid = 1'b1;
    tb_a = 16'hAA; tb_b = 16'h11;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(o_out_valid), 32'd1);
      check("bp_sum", 32'(o_sum), 32'h30);
      check("bp_cout", 32'(o_cout), 32'd0);
      check("bp_ovf", 32'(o_ovf), 32'd0);
      check("bp_in_ready", 32'(o_in_ready), 32'd0);
      tick();
    end
    tb_in_valid  = 1'b0;
    tb_out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_single_xfer", 32'(o_out_valid), 32'd0);
      check("bp_no_new_op", 32'(o_busy), 32'd0);
      check("bp_sum_kept", 32'(o_sum), 32'h30);
      tick();
    end

    // Reset in the third ADD cycle abandons the operation
    tb_a = 16'h55; tb_b = 16'h22; tb_cin = 1'b0; tb_sub = 1'b0;
    tb_in_valid = 1'b1;
    tick();
    tb_in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", 32'(o_in_ready), 32'd1);
    check("midrst_out_valid", 32'(o_out_valid), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_sum", 32'(o_sum), 32'd0);
    for (int i = 0; i < 10; i++) begin
      check("midrst_no_result", 32'(o_out_valid), 32'd0);
      tick();
    end
    do_op("add_12_34", 16'h12, 16'h34, 1'b0, 1'b0, 16'h46, 1'b0, 1'b0, 8);

    // WIDTH=8, DIGIT=4, subtraction (cin must be ignored)
    sel = 1;
    tick();
    do_op("sub_00_01", 16'h00, 16'h01, 1'b1, 1'b1, 16'hFF, 1'b0, 1'b0, 2);
    do_op("sub_80_01", 16'h80, 16'h01, 1'b0, 1'b1, SAT ? 16'h80 : 16'h7F, 1'b1, 1'b1, 2);
    do_op("sub_05_05", 16'h05, 16'h05, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0, 2);

    // WIDTH=16, DIGIT=4: random back-to-back traffic with random out_ready
    sel = 2;
    tick();
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        full  = {1'b0, ra} + {1'b0, ~rb} + 17'd1;
        e_ovf = (ra[15] != rb[15]) && (full[15] != ra[15]);
      end else begin
        full  = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        e_ovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
      end
      e_sum = full[15:0];
      if (SAT && e_ovf) e_sum = ra[15] ? 16'h8000 : 16'h7FFF;

      tb_a = ra; tb_b = rb; tb_cin = rc; tb_sub = rs;
      tb_in_valid  = 1'b1;
      tb_out_ready = 1'($urandom_range(0, 1));
      guard = 0;
      while (!o_in_ready && guard < 50) begin
        tick();
        guard++;
      end
      tick();
      tb_in_valid = 1'b0;
      guard = 0;
      forever begin
        tb_out_ready = 1'($urandom_range(0, 1));
        if (o_out_valid && tb_out_ready) begin
          check("rnd_sum", 32'(o_sum), 32'(e_sum));
          check("rnd_cout", 32'(o_cout), 32'(full[16]));
          check("rnd_ovf", 32'(o_ovf), 32'(e_ovf));
          tick();
          break;
        end
        tick();
        guard++;
        if (guard > 100) begin
          check("rnd_timeout", 32'd1, 32'd0);
          break;
        end
      end
    end
    tb_out_ready = 1'b1;
    tick();
    tick();
    check("rnd_xfer_count", 32'(n_xfer), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
